// File: rtl/flashy_btn_ctrl.sv
// Button front end for the RSLK LED flasher: sync, debounce, short/long
// press classification, pattern mode and run/pause control.
module flashy_btn_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 320000,
  parameter int LONG_CYCLES     = 16000000,
  parameter int NUM_MODES       = 4
) (
  input  logic       WF_CLK,
  input  logic       rst_n,
  input  logic       WF_BUTTON,
  output logic       btn_level,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [1:0] mode,
  output logic       run
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LONG_CYCLES > 2) ?
                      $clog2(LONG_CYCLES) : 1;

  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES - 1);
  localparam logic [1:0]    MODE_MAX = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_raw;

  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_cnt_nxt;
  logic          lvl_nxt;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] hold_cnt;
  logic [LW-1:0] hold_nxt;

  logic short_nxt;
  logic long_nxt;

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ~WF_BUTTON};
    end
  end

  assign btn_raw = sync[SYNC_STAGES-1];

  always_comb begin
    db_cnt_nxt = '0;
    lvl_nxt    = btn_level;
    if (btn_raw != btn_level) begin
      if (db_cnt == DB_MAX) begin
        lvl_nxt = btn_raw;
      end else begin
        db_cnt_nxt = db_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      db_cnt    <= db_cnt_nxt;
      btn_level <= lvl_nxt;
    end
  end

  // The FSM looks at the level being accepted on this edge, so a release
  // landing on the final hold cycle is seen before the long threshold.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (lvl_nxt) begin
          state_nxt = HELD;
          hold_nxt  = '0;
        end
      end
      HELD: begin
        if (!lvl_nxt) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = LONG;
        end else begin
          hold_nxt = hold_cnt + LW'(1);
        end
      end
      LONG: begin
        if (!lvl_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    if (state == HELD) begin
      short_nxt = !lvl_nxt;
      long_nxt  = lvl_nxt && (hold_cnt == HOLD_MAX);
    end
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      mode        <= 2'd0;
      run         <= 1'b1;
    end else begin
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
      if (short_nxt) begin
        mode <= (mode == MODE_MAX) ? 2'd0 : mode + 2'd1;
      end
      if (long_nxt) begin
        run <= ~run;
      end
    end
  end

endmodule

// File: doc/flashy_btn_ctrl.md
# flashy_btn_ctrl

Upstream control stage for the RSLK LED flasher. Synchronises and debounces the raw Shasta push-button and classifies each press as short or long. Maintains a wrapping pattern-mode register and a run/pause flag. The flasher consumes `mode` and `run` to pick and gate its LED sequence.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on the raw button; minimum 2.
- `DEBOUNCE_CYCLES`, default 320000: consecutive cycles a new level must persist before acceptance (20 ms at 16 MHz); minimum 2.
- `LONG_CYCLES`, default 16000000: hold time, in cycles from debounced press, that classifies a press as long (1 s); must be greater than 1.
- `NUM_MODES`, default 4: number of flasher patterns; 2..4.

- `WF_CLK`  in  1  system clock, 16 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `WF_BUTTON`  in  1  raw button, asynchronous; active-low (0 = pressed).
- `btn_level`  out  1  debounced pressed level (1 = pressed).
- `short_pulse`  out  1  one-cycle strobe on release of a short press.
- `long_pulse`  out  1  one-cycle strobe when a hold reaches `LONG_CYCLES`.
- `mode`  out  2  current pattern index, 0..`NUM_MODES`-1.
- `run`  out  1  1 = flasher runs, 0 = paused.

## Operation
- **Synchroniser.** `WF_BUTTON` is inverted, then passed through `SYNC_STAGES` flops. All flops reset to 0 (not pressed).
- **Debouncer.**
  - The counter (width clog2(`DEBOUNCE_CYCLES`)) increments while the synchronised value differs from `btn_level`.
  - Any cycle of agreement clears the counter to 0.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and the mismatch persists, `btn_level` takes the synchronised value on that edge and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` never reach `btn_level`.
- **Press FSM**, states IDLE, HELD, LONG:
  - IDLE: when `btn_level` goes 1, go to HELD and clear the hold counter (width clog2(`LONG_CYCLES`)).
  - HELD: the hold counter increments each cycle.
    - If `btn_level` goes 0, assert `short_pulse` and return to IDLE.
    - Otherwise, when the counter equals `LONG_CYCLES`-1, assert `long_pulse` and go to LONG.
  - LONG: wait for `btn_level` 0, then go to IDLE. No pulse on this release.
- **Mode register.** On `short_pulse`, `mode` becomes `mode`+1, or 0 when `mode` = `NUM_MODES`-1 (wrap).
- **Run flag.** On `long_pulse`, `run` toggles. A long press never changes `mode`.
- `short_pulse` and `long_pulse` are mutually exclusive by construction; at most one press event per physical press.
- **Reset values:** `btn_level` 0, `short_pulse` 0, `long_pulse` 0, `mode` 0, `run` 1; FSM IDLE; all counters 0.
- **Reset mid-operation.** Asserting `rst_n` mid-hold or mid-debounce forces the reset values immediately (asynchronously). The in-progress press is discarded. After release of reset, a button still held must re-debounce and is treated as a new press.

## Timing
- Raw press to `btn_level` = 1: `SYNC_STAGES` + `DEBOUNCE_CYCLES` edges for a clean press. Release takes the same latency.
- `short_pulse` is high in the cycle after the edge where `btn_level` falls from HELD. `mode` shows the new value in that same cycle.
- `long_pulse` is high in the cycle after the edge where the hold counter reaches `LONG_CYCLES`-1, i.e. `LONG_CYCLES` cycles after `btn_level` rose. `run` toggles on that same edge.
- Release in exactly the cycle the hold counter reaches `LONG_CYCLES`-1: release wins, producing `short_pulse` only.
- All outputs are registered; no combinational path from `WF_BUTTON` to any output.
- Pulses are exactly one cycle wide regardless of hold duration.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `NUM_MODES`=3.

- **Reset:** hold `rst_n`=0 with `WF_BUTTON`=1 → `mode`=0, `run`=1, all pulses 0, `btn_level`=0.
- **Debounce reject:** drive `WF_BUTTON`=0 for 3 cycles, then 1 → `btn_level` stays 0, no pulses, `mode` stays 0.
- **Short press and wrap:** press for 10 cycles, release; repeat three times → `btn_level` rises 6 cycles after each press. Exactly one `short_pulse` per press, and `mode` goes 1, 2, 0.
- **Long press:** hold for 40 cycles → `long_pulse` once, exactly 20 cycles after `btn_level` rose. `run` goes 1→0, `mode` unchanged, no `short_pulse` on release. A second 40-cycle hold returns `run` to 1.
- **Boundary:** release so `btn_level` falls on the edge where the hold counter = 19 → `short_pulse` only; `mode` increments, `run` unchanged.
- **Reset mid-hold:** assert `rst_n`=0 at hold count 15 while `mode`=2 and `run`=0 → immediately `mode`=0 and `run`=1. After release of reset with the button still held, `btn_level` re-rises after 6 cycles and the hold restarts from 0.
